lcd_cmd_sched: RTL and testbench
================================

Name: lcd_cmd_sched

Overview:
Command scheduler that sits between a host/test sequencer and the LCD image controller. It buffers host opcodes in a small FIFO and issues them to the controller as single-cycle cmd/cmd_valid pulses, only while the controller is not busy. It sequences the session boot wait, command stream, write-back (opcode 0), done wait and finished, and reports status to the host.

Parameters:
DEPTH, 8, FIFO entries (power of 2, >=2)
LVL_W, 4, width of fifo_level (log2(DEPTH)+1)
CNT_W, 8, width of issued-command counter (saturating)
TIMEOUT_CYC, 256, watchdog limit in cycles (used only with LCD_SCHED_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high
host_cmd  in  3  opcode: 0 WRTBK, 1 UP, 2 DN, 3 LF, 4 RT, 5 AVG, 6 MRR_X, 7 MRR_Y
host_valid  in  1  host offers host_cmd
host_ready  out  1  push accepted when host_valid&host_ready
lcd_busy  in  1  controller busy (high during image load and write-back)
lcd_done  in  1  controller write-back complete
lcd_cmd  out  3  opcode to controller
lcd_cmd_valid  out  1  one-cycle issue strobe
fifo_level  out  LVL_W  entries currently queued
issued_cnt  out  CNT_W  commands issued this session, saturates at all-ones
sched_idle  out  1  state RUN and FIFO empty
finished  out  1  session complete (sticky until reset)
err  out  1  watchdog fired (only with LCD_SCHED_TIMEOUT_EN; else tied 0)

Behaviour:
- Reset (async): state BOOT, FIFO empty, wb_queued=0; outputs lcd_cmd=0, lcd_cmd_valid=0, fifo_level=0, issued_cnt=0, finished=0, err=0, sched_idle=0, host_ready=0. Reset mid-session discards all queued commands.
- host_ready = !full & !wb_queued & state!=FIN (combinational). No push-through: push while full is not accepted. wb_queued set when an opcode 0 is pushed; no pushes thereafter.
- Push and pop in same cycle: both happen, level unchanged. Pop never from empty.
- States: BOOT: wait lcd_busy=0 sampled on an edge -> RUN. RUN: pop when FIFO non-empty & lcd_busy=0; register popped opcode to lcd_cmd, lcd_cmd_valid=1 for exactly the next cycle; issued_cnt+1. If popped opcode==0 -> WB. WB: no pops; lcd_cmd_valid=0; wait lcd_done=1 -> FIN. FIN: finished=1, host_ready=0, no issue; held until reset.
- Pushes are accepted in BOOT (queued, not issued).
- lcd_busy rising in RUN (unexpected): pop suspended while high; the registered strobe already launched still completes.
- Latency: push accepted at edge t -> lcd_cmd_valid high in cycle after edge t+1 (2 cycles), if RUN and lcd_busy=0.
- Back-to-back issue allowed: continuous non-empty FIFO gives consecutive valid cycles.
- lcd_cmd holds last issued opcode when lcd_cmd_valid=0.
- FIFO pointers are log2(DEPTH) bits with natural wrap; level is LVL_W bits, 0..DEPTH.

Optional Feature:
LCD_SCHED_TIMEOUT_EN: defined -> a counter runs in BOOT and WB and clears on state exit; when it reaches TIMEOUT_CYC, err=1 (sticky), state -> FIN, finished=1. Undefined -> no counter, err tied 0, BOOT/WB wait indefinitely.

Decomposition:
- Package lcd_sched_pkg: opcode constants (OP_WRTBK..OP_MRR_Y), state encoding (BOOT, RUN, WB, FIN).
- Sub-module lcd_cmd_fifo (DEPTH x 3-bit sync FIFO with full/empty/level); FSM, counters and output registers live in top.

Test Plan:
- Boot: lcd_busy=1 for 70 cycles after reset, push UP,RT -> no lcd_cmd_valid until busy low; then valid with cmd 1, then 4 on consecutive cycles; issued_cnt=2.
- Fill: lcd_busy=1, push 9 cmds, DEPTH=8 -> 8 accepted, host_ready=0 at fifo_level=8; pop one -> host_ready=1.
- Write-back: push AVG, WRTBK, then MRR_X -> MRR_X refused (host_ready=0); cmd 5 then cmd 0 issued; lcd_done pulse -> finished=1, no further lcd_cmd_valid.
- Busy stall: RUN with 3 queued, raise lcd_busy 5 cycles mid-stream -> no valid while busy; remaining commands issue in order after busy falls.
- Reset mid-stream: 4 queued, assert reset -> fifo_level=0, issued_cnt=0, state BOOT, lcd_cmd_valid=0 immediately.
- (LCD_SCHED_TIMEOUT_EN) WRTBK issued, lcd_done never asserted -> err=1 and finished=1 exactly TIMEOUT_CYC=256 cycles after WB entry.

Source files
------------

// File: rtl/lcd_cmd_sched_pkg.sv
// lcd_cmd_sched shared types: opcodes and scheduler states.
// Imported by the FIFO, the interface users and the top.
package lcd_sched_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_WRTBK = 3'd0;
  localparam op_t OP_UP    = 3'd1;
  localparam op_t OP_DN    = 3'd2;
  localparam op_t OP_LF    = 3'd3;
  localparam op_t OP_RT    = 3'd4;
  localparam op_t OP_AVG   = 3'd5;
  localparam op_t OP_MRR_X = 3'd6;
  localparam op_t OP_MRR_Y = 3'd7;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/lcd_cmd_sched_if.sv
// Host-side opcode push handshake for lcd_cmd_sched.
// master = host/sequencer, slave = scheduler.
interface lcd_cmd_sched_if;
  import lcd_sched_pkg::*;

  op_t  host_cmd;
  logic host_valid;
  logic host_ready;

  modport master (
    output host_cmd,
    output host_valid,
    input  host_ready
  );

  modport slave (
    input  host_cmd,
    input  host_valid,
    output host_ready
  );

endinterface

// File: rtl/lcd_cmd_sched_fifo.sv
// DEPTH x 3-bit synchronous FIFO with full/empty/level.
// Pointers wrap naturally; the caller never pushes full or pops empty.
module lcd_cmd_fifo
  import lcd_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LVL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  op_t              din_i,
  input  logic             pop_i,
  output op_t              dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);

  op_t              mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // Next pointers and level from push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/lcd_cmd_sched.sv
// LCD command scheduler: queues host opcodes, issues them as strobes.
// Optional watchdog on BOOT/WB waits: define LCD_SCHED_TIMEOUT_EN.
module lcd_cmd_sched
  import lcd_sched_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int LVL_W       = 4,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic             clk,
  input  logic             reset,
  lcd_cmd_sched_if.slave   host,
  input  logic             lcd_busy,
  input  logic             lcd_done,
  output op_t              lcd_cmd,
  output logic             lcd_cmd_valid,
  output logic [LVL_W-1:0] fifo_level,
  output logic [CNT_W-1:0] issued_cnt,
  output logic             sched_idle,
  output logic             finished,
  output logic             err
);

  if (DEPTH < 2 || (1 << $clog2(DEPTH)) != DEPTH ||
      LVL_W != $clog2(DEPTH) + 1 || TIMEOUT_CYC < 1)
  begin : g_cfg_err
    $error("lcd_cmd_sched: inconsistent parameters");
  end

  state_t           state_q, state_d;
  op_t              cmd_q, cmd_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wbq_q, wbq_d;

  op_t              f_dout;
  logic             f_full;
  logic             f_empty;
  logic [LVL_W-1:0] f_level;

  logic             push;
  logic             pop;
  logic             tmo_hit;

  assign host.host_ready = ~reset & ~f_full & ~wbq_q &
                           (state_q != FIN);
  assign push = host.host_valid & host.host_ready;
  assign pop  = (state_q == RUN) & ~f_empty & ~lcd_busy;

  lcd_cmd_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (host.host_cmd),
    .pop_i   (pop),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty),
    .level_o (f_level)
  );

`ifdef LCD_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             waiting;

  assign waiting = (state_q == BOOT) | (state_q == WB);
  assign tmo_hit = waiting &
                   (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // Watchdog counts while waiting, clears when the state moves on.
  always_comb begin
    tmo_d = '0;
    err_d = err_q | tmo_hit;
    if (waiting && state_d == state_q) tmo_d = tmo_q + 1'b1;
  end

  // Watchdog registers; err is sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // Session sequencing, issue strobe and counters.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    vld_d   = 1'b0;
    cnt_d   = cnt_q;
    wbq_d   = wbq_q;
    if (push && host.host_cmd == OP_WRTBK) wbq_d = 1'b1;
    if (pop) begin
      cmd_d = f_dout;
      vld_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
    unique case (state_q)
      BOOT: if (!lcd_busy) state_d = RUN;
      RUN:  if (pop && f_dout == OP_WRTBK) state_d = WB;
      WB:   if (lcd_done) state_d = FIN;
      FIN:  state_d = FIN;
      default: state_d = BOOT;
    endcase
    if (tmo_hit) state_d = FIN;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      cmd_q   <= OP_WRTBK;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
      wbq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      wbq_q   <= wbq_d;
    end
  end

  assign lcd_cmd       = cmd_q;
  assign lcd_cmd_valid = vld_q;
  assign fifo_level    = f_level;
  assign issued_cnt    = cnt_q;
  assign sched_idle    = (state_q == RUN) & f_empty;
  assign finished      = (state_q == FIN);

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed, table-driven bench for lcd_cmd_sched.
// Watchdog sequence is compiled in with LCD_SCHED_TIMEOUT_EN.
module tb_lcd_cmd_sched;
  import lcd_sched_pkg::*;

  logic       clk;
  logic       reset;
  logic       lcd_busy;
  logic       lcd_done;
  op_t        lcd_cmd;
  logic       lcd_cmd_valid;
  logic [3:0] fifo_level;
  logic [7:0] issued_cnt;
  logic       sched_idle;
  logic       finished;
  logic       err;

  int checks;
  int failures;

  lcd_cmd_sched_if hif ();

  lcd_cmd_sched dut (
    .clk           (clk),
    .reset         (reset),
    .host          (hif),
    .lcd_busy      (lcd_busy),
    .lcd_done      (lcd_done),
    .lcd_cmd       (lcd_cmd),
    .lcd_cmd_valid (lcd_cmd_valid),
    .fifo_level    (fifo_level),
    .issued_cnt    (issued_cnt),
    .sched_idle    (sched_idle),
    .finished      (finished),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -1 in an expected field means "not checked in this step".
  typedef struct {
    logic [2:0] cmd;
    bit         hv;
    bit         busy;
    bit         done;
    int         vld;
    int         op;
    int         lvl;
    int         rdy;
    int         idl;
    int         cnt;
    int         fin;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string nm, input int act, input int exp);
    if (exp >= 0) begin
      checks++;
      if (act != exp) begin
        failures++;
        $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
    end
  endtask

  task automatic add(input logic [2:0] c, input bit hv,
                     input bit busy, input bit done,
                     input int vld, input int op, input int lvl,
                     input int rdy, input int idl, input int cnt,
                     input int fin);
    vec_t v;
    v.cmd = c;   v.hv = hv;   v.busy = busy; v.done = done;
    v.vld = vld; v.op = op;   v.lvl = lvl;   v.rdy = rdy;
    v.idl = idl; v.cnt = cnt; v.fin = fin;
    tab.push_back(v);
  endtask

  // Drive each row at a falling edge, check after the next rising edge.
  task automatic run_tab(input string nm);
    foreach (tab[i]) begin
      hif.host_cmd   = tab[i].cmd;
      hif.host_valid = tab[i].hv;
      lcd_busy       = tab[i].busy;
      lcd_done       = tab[i].done;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s[%0d].vld", nm, i),
          int'(lcd_cmd_valid), tab[i].vld);
      chk($sformatf("%s[%0d].cmd", nm, i),
          int'(lcd_cmd), tab[i].op);
      chk($sformatf("%s[%0d].lvl", nm, i),
          int'(fifo_level), tab[i].lvl);
      chk($sformatf("%s[%0d].rdy", nm, i),
          int'(hif.host_ready), tab[i].rdy);
      chk($sformatf("%s[%0d].idle", nm, i),
          int'(sched_idle), tab[i].idl);
      chk($sformatf("%s[%0d].cnt", nm, i),
          int'(issued_cnt), tab[i].cnt);
      chk($sformatf("%s[%0d].fin", nm, i),
          int'(finished), tab[i].fin);
    end
    tab.delete();
    hif.host_valid = 1'b0;
    lcd_done       = 1'b0;
  endtask

  // Assert reset mid-cycle, check outputs at once, release at next fall.
  task automatic do_reset(input string nm);
    reset = 1'b1;
    #1;
    chk({nm, ".vld"},  int'(lcd_cmd_valid), 0);
    chk({nm, ".lvl"},  int'(fifo_level), 0);
    chk({nm, ".cnt"},  int'(issued_cnt), 0);
    chk({nm, ".rdy"},  int'(hif.host_ready), 0);
    chk({nm, ".idle"}, int'(sched_idle), 0);
    chk({nm, ".fin"},  int'(finished), 0);
    chk({nm, ".err"},  int'(err), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    lcd_busy       = 1'b1;
    lcd_done       = 1'b0;
    hif.host_cmd   = 3'd0;
    hif.host_valid = 1'b0;
    #3;
    chk("por.vld",  int'(lcd_cmd_valid), 0);
    chk("por.cmd",  int'(lcd_cmd), 0);
    chk("por.lvl",  int'(fifo_level), 0);
    chk("por.cnt",  int'(issued_cnt), 0);
    chk("por.rdy",  int'(hif.host_ready), 0);
    chk("por.idle", int'(sched_idle), 0);
    chk("por.fin",  int'(finished), 0);
    chk("por.err",  int'(err), 0);
    @(negedge clk);
    reset = 1'b0;

    // Boot wait with two queued, then back-to-back issue.
    add(1, 1, 1, 0,  0, -1, 1, 1, 0, 0, 0);
    add(4, 1, 1, 0,  0, -1, 2, 1, 0, 0, 0);
    for (int k = 0; k < 68; k++)
      add(0, 0, 1, 0,  0, -1, 2, 1, 0, 0, 0);
    add(0, 0, 0, 0,  0, -1, 2, 1, 0, 0, 0);
    add(0, 0, 0, 0,  1,  1, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0,  1,  4, 0, 1, 1, 2, 0);
    add(0, 0, 0, 0,  0,  4, 0, 1, 1, 2, 0);
    // Two-cycle latency, then push+pop in one cycle.
    add(5, 1, 0, 0,  0,  4, 1, 1, 0, 2, 0);
    add(0, 0, 0, 0,  1,  5, 0, 1, 1, 3, 0);
    add(2, 1, 0, 0,  0,  5, 1, 1, 0, 3, 0);
    add(3, 1, 0, 0,  1,  2, 1, 1, 0, 4, 0);
    add(0, 0, 0, 0,  1,  3, 0, 1, 1, 5, 0);
    add(0, 0, 0, 0,  0,  3, 0, 1, 1, 5, 0);
    // Busy stall mid-stream.
    add(6, 1, 1, 0,  0,  3, 1, 1, 0, 5, 0);
    add(7, 1, 1, 0,  0,  3, 2, 1, 0, 5, 0);
    add(1, 1, 1, 0,  0,  3, 3, 1, 0, 5, 0);
    add(0, 0, 0, 0,  1,  6, 2, 1, 0, 6, 0);
    for (int k = 0; k < 5; k++)
      add(0, 0, 1, 0,  0,  6, 2, 1, 0, 6, 0);
    add(0, 0, 0, 0,  1,  7, 1, 1, 0, 7, 0);
    add(0, 0, 0, 0,  1,  1, 0, 1, 1, 8, 0);
    add(0, 0, 0, 0,  0,  1, 0, 1, 1, 8, 0);
    // Write-back: later push refused, done ends the session.
    add(5, 1, 1, 0,  0, -1, 1, 1, 0, 8, 0);
    add(0, 1, 1, 0,  0, -1, 2, 0, 0, 8, 0);
    add(6, 1, 1, 0,  0, -1, 2, 0, 0, 8, 0);
    add(0, 0, 0, 0,  1,  5, 1, 0, 0, 9, 0);
    add(0, 0, 0, 0,  1,  0, 0, 0, 0, 10, 0);
    for (int k = 0; k < 3; k++)
      add(0, 0, 1, 0,  0,  0, 0, 0, 0, 10, 0);
    add(0, 0, 1, 1,  0,  0, 0, 0, 0, 10, 1);
    add(1, 1, 0, 0,  0,  0, 0, 0, 0, 10, 1);
    for (int k = 0; k < 3; k++)
      add(0, 0, 0, 0,  0,  0, 0, 0, 0, 10, 1);
    run_tab("main");
    chk("main.err", int'(err), 0);

    // Fill past DEPTH, pop one, refill (pointer wrap), drain in order.
    lcd_busy = 1'b1;
    do_reset("rst1");
    for (int k = 1; k <= 8; k++)
      add(3'((k - 1) % 7 + 1), 1, 1, 0,
          0, -1, k, (k < 8) ? 1 : 0, 0, 0, 0);
    add(2, 1, 1, 0,  0, -1, 8, 0, 0, 0, 0);
    add(0, 0, 0, 0,  0, -1, 8, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1,  1, 7, 1, 0, 1, 0);
    add(3, 1, 1, 0,  0,  1, 8, 0, 0, 1, 0);
    add(0, 0, 0, 0,  1,  2, 7, 1, 0, 2, 0);
    add(0, 0, 0, 0,  1,  3, 6, 1, 0, 3, 0);
    add(0, 0, 0, 0,  1,  4, 5, 1, 0, 4, 0);
    add(0, 0, 0, 0,  1,  5, 4, 1, 0, 5, 0);
    add(0, 0, 0, 0,  1,  6, 3, 1, 0, 6, 0);
    add(0, 0, 0, 0,  1,  7, 2, 1, 0, 7, 0);
    add(0, 0, 0, 0,  1,  1, 1, 1, 0, 8, 0);
    add(0, 0, 0, 0,  1,  3, 0, 1, 1, 9, 0);
    add(0, 0, 0, 0,  0,  3, 0, 1, 1, 9, 0);
    // Four queued, one issued, then reset mid-strobe.
    add(2, 1, 1, 0,  0,  3, 1, 1, 0, 9, 0);
    add(3, 1, 1, 0,  0,  3, 2, 1, 0, 9, 0);
    add(4, 1, 1, 0,  0,  3, 3, 1, 0, 9, 0);
    add(5, 1, 1, 0,  0,  3, 4, 1, 0, 9, 0);
    add(0, 0, 0, 0,  1,  2, 3, 1, 0, 10, 0);
    run_tab("fill");
    #2;
    do_reset("rst2");
    add(0, 0, 0, 0,  0,  0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0,  0,  0, 0, 1, 1, 0, 0);
    run_tab("post");

`ifdef LCD_SCHED_TIMEOUT_EN
    do_reset("rst3");
    add(0, 1, 0, 0,  0, -1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1,  0, 0, 0, 0, 1, 0);
    run_tab("tmo_setup");
    lcd_busy = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k >= 250) begin
        chk($sformatf("tmo[%0d].fin", k),
            int'(finished), (k == 256) ? 1 : 0);
        chk($sformatf("tmo[%0d].err", k),
            int'(err), (k == 256) ? 1 : 0);
      end else if (finished || err) begin
        chk($sformatf("tmo[%0d].early", k), 1, 0);
      end
    end
    @(negedge clk);
    chk("tmo.err_sticky", int'(err), 1);
    chk("tmo.fin_sticky", int'(finished), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
